// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS instruction fetch stage: PC generation, imem request and decode FIFO
//
// Purpose: generates the fetch PC and issues one read per cycle to a
// synchronous instruction memory. Returned words are buffered with their
// addresses in a DEPTH-entry FIFO and presented to decode through a
// valid/ready handshake. A redirect flushes all fetched-but-unconsumed work.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN (sticky misaligned-redirect fault).
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   imem_req, imem_addr      read request and word-aligned byte address
//   imem_rdata               read data, valid one cycle after the request
//   redirect, redirect_pc    taken branch/jump pulse and its target
//   id_valid, id_ready       decode handshake for the FIFO head
//   id_instr, id_pc          head instruction word and its byte address
//   id_opcode                id_instr[31:26] for the control unit
//   misaligned               sticky fault (FETCH_ALIGN_CHECK_EN only)
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [5:0]  id_opcode
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic        misaligned
`endif
);

   localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW      = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   ipc_q, ipc_d;          // address of the request now in flight
   logic          inflight_q, inflight_d;
   logic          kill_q, kill_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   pc_mem_d    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   instr_mem_d [DEPTH];

   logic          pop;
   logic          push;
   logic          issue;
   logic          halt;
   logic [CW:0]   occupancy;
   logic [31:0]   target_pc;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned_q, misaligned_d;
   assign halt       = misaligned_q;
   assign misaligned = misaligned_q;
`else
   assign halt = 1'b0;
`endif

   // Low address bits of a redirect are never fetched from.
   assign target_pc = redirect_pc & 32'hFFFF_FFFC;

   assign id_valid  = (count_q != '0);
   assign id_instr  = instr_mem_q[rd_ptr_q];
   assign id_pc     = pc_mem_q[rd_ptr_q];
   assign id_opcode = id_instr[31:26];

   assign pop  = id_valid && id_ready;
   assign push = inflight_q && !kill_q && !redirect;

   // Slots committed after this cycle: the in-flight response still needs a
   // slot, so issuing only while this is below DEPTH makes overflow impossible.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
   assign issue     = !reset && !redirect && !halt && (occupancy < DEPTH_W);

   assign imem_req  = issue;
   assign imem_addr = pc_q;

   always_comb begin
      pc_d        = pc_q;
      ipc_d       = ipc_q;
      inflight_d  = issue;
      // Nothing issues in a redirect cycle, so there is normally nothing to kill.
      kill_d      = redirect && issue;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q + CW'(push) - CW'(pop);
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned_d = misaligned_q || (redirect && (redirect_pc[1:0] != 2'b00));
`endif

      if (push) begin
         pc_mem_d[wr_ptr_q]    = ipc_q;
         instr_mem_d[wr_ptr_q] = imem_rdata;
         wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (issue) begin
         ipc_d = pc_q;
         pc_d  = pc_q + 32'd4;
      end

      // Redirect wins over everything: a coincident pop has already been
      // taken by decode, and the rest of the FIFO is discarded.
      if (redirect) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         pc_d     = target_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         ipc_q       <= RESET_PC;
         inflight_q  <= 1'b0;
         kill_q      <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         pc_mem_q    <= '{default: '0};
         instr_mem_q <= '{default: '0};
`ifdef FETCH_ALIGN_CHECK_EN
         misaligned_q <= 1'b0;
`endif
      end else begin
         pc_q        <= pc_d;
         ipc_q       <= ipc_d;
         inflight_q  <= inflight_d;
         kill_q      <= kill_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
`ifdef FETCH_ALIGN_CHECK_EN
         misaligned_q <= misaligned_d;
`endif
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a queue-based fetch model
module tb_instr_fetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [5:0]  id_opcode;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misaligned;
`endif

   instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .id_valid(id_valid),
      .id_ready(id_ready),
      .id_instr(id_instr),
      .id_pc(id_pc),
      .id_opcode(id_opcode)
`ifdef FETCH_ALIGN_CHECK_EN
      , .misaligned(misaligned)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: queue of fetched {pc, instr}, fetch pointer, one in-flight slot.
   logic [31:0] mq_pc[$];
   logic [31:0] mq_instr[$];
   logic [31:0] m_pc;
   logic [31:0] m_ipc;
   bit          m_inflight;
   bit          m_halt;

   // DUT values sampled at the last step, for scenario-level checks.
   logic        s_req;
   logic [31:0] s_addr;
   logic        s_valid;
   logic [31:0] s_pc;
   logic [31:0] s_instr;

   task automatic model_reset();
      mq_pc.delete();
      mq_instr.delete();
      m_pc       = RESET_PC;
      m_ipc      = RESET_PC;
      m_inflight = 0;
      m_halt     = 0;
      cyc        = 0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      redirect = 1'b0;
      id_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // One clock cycle: compare DUT outputs to the model, advance the model,
   // then play the memory: answer the sampled request one cycle later.
   task automatic step();
      bit          e_valid, e_pop, e_req;
      logic [31:0] h_pc, h_instr;
      logic [5:0]  h_op;
      @(negedge clk);
      e_valid = (mq_pc.size() > 0);
      e_pop   = e_valid && id_ready;
      e_req   = !redirect && !m_halt &&
                ((mq_pc.size() + int'(m_inflight) - int'(e_pop)) < DEPTH);
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = id_valid;
      s_pc    = id_pc;
      s_instr = id_instr;

      checks++;
      if (imem_req !== e_req) begin
         failures++;
         $display("FAIL imem_req cyc=%0d got %b expected %b", cyc, imem_req, e_req);
      end
      checks++;
      if (imem_addr !== m_pc) begin
         failures++;
         $display("FAIL imem_addr cyc=%0d got %h expected %h", cyc, imem_addr, m_pc);
      end
      checks++;
      if (id_valid !== e_valid) begin
         failures++;
         $display("FAIL id_valid cyc=%0d got %b expected %b", cyc, id_valid, e_valid);
      end
`ifdef FETCH_ALIGN_CHECK_EN
      checks++;
      if (misaligned !== m_halt) begin
         failures++;
         $display("FAIL misaligned cyc=%0d got %b expected %b", cyc, misaligned, m_halt);
      end
`endif
      if (e_valid) begin
         h_pc    = mq_pc[0];
         h_instr = mq_instr[0];
         h_op    = h_instr[31:26];
         checks++;
         if (id_pc !== h_pc) begin
            failures++;
            $display("FAIL id_pc cyc=%0d got %h expected %h", cyc, id_pc, h_pc);
         end
         checks++;
         if (id_instr !== h_instr) begin
            failures++;
            $display("FAIL id_instr cyc=%0d got %h expected %h", cyc, id_instr, h_instr);
         end
         checks++;
         if (id_opcode !== h_op) begin
            failures++;
            $display("FAIL id_opcode cyc=%0d got %h expected %h", cyc, id_opcode, h_op);
         end
      end

      if (e_pop) begin
         void'(mq_pc.pop_front());
         void'(mq_instr.pop_front());
      end
      if (m_inflight && !redirect) begin
         mq_pc.push_back(m_ipc);
         mq_instr.push_back(m_ipc ^ KEY);
      end
      if (redirect) begin
         mq_pc.delete();
         mq_instr.delete();
         m_pc       = redirect_pc & 32'hFFFF_FFFC;
         m_inflight = 0;
`ifdef FETCH_ALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) m_halt = 1;
`endif
      end else if (e_req) begin
         m_ipc      = m_pc;
         m_pc       = m_pc + 32'd4;
         m_inflight = 1;
      end else begin
         m_inflight = 0;
      end

      @(posedge clk);
      #1;
      imem_rdata = s_req ? (s_addr ^ KEY) : $urandom();
      redirect   = 1'b0;
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl got req=%b valid=%b expected 0 0", imem_req, id_valid);
      end
      checks++;
      if (id_instr !== 32'h0 || id_pc !== 32'h0 || id_opcode !== 6'h0) begin
         failures++;
         $display("FAIL reset_data got instr=%h pc=%h op=%h expected 0", id_instr, id_pc, id_opcode);
      end
      checks++;
      if (imem_addr !== RESET_PC) begin
         failures++;
         $display("FAIL reset_addr got %h expected %h", imem_addr, RESET_PC);
      end
   endtask

   task automatic test_stream();
      int first_valid;
      first_valid = -1;
      do_reset();
      id_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         checks++;
         if (s_req !== 1'b1 || s_addr !== 32'(4 * i)) begin
            failures++;
            $display("FAIL stream_addr i=%0d got req=%b addr=%h expected 1 %h", i, s_req, s_addr, 32'(4 * i));
         end
         if (s_valid === 1'b1 && first_valid < 0) begin
            first_valid = i;
            checks++;
            if (s_pc !== 32'h0 || s_instr !== 32'hA5A5_0000) begin
               failures++;
               $display("FAIL stream_first got pc=%h instr=%h expected 0 a5a50000", s_pc, s_instr);
            end
         end
      end
      checks++;
      if (first_valid != 2) begin
         failures++;
         $display("FAIL stream_latency got %0d expected 2", first_valid);
      end
   endtask

   task automatic test_backpressure();
      int reqs;
      reqs = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step();
         if (s_req === 1'b1) reqs++;
      end
      checks++;
      if (reqs != DEPTH || s_req !== 1'b0 || s_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_fill got reqs=%0d req=%b valid=%b expected %0d 0 1", reqs, s_req, s_valid, DEPTH);
      end
      id_ready = 1'b1;
      step();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h10 || s_pc !== 32'h0) begin
         failures++;
         $display("FAIL bp_first_pop got req=%b addr=%h pc=%h expected 1 10 0", s_req, s_addr, s_pc);
      end
      for (int k = 1; k < 4; k++) begin
         step();
         checks++;
         if (s_pc !== 32'(4 * k)) begin
            failures++;
            $display("FAIL bp_order k=%0d got %h expected %h", k, s_pc, 32'(4 * k));
         end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      repeat (4) step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      step();
      id_ready = 1'b1;
      step();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h100 || s_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir_issue got req=%b addr=%h valid=%b expected 1 100 0", s_req, s_addr, s_valid);
      end
      step();
      checks++;
      if (s_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir_gap got valid=%b expected 0", s_valid);
      end
      step();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== (32'h100 ^ KEY)) begin
         failures++;
         $display("FAIL redir_first got valid=%b pc=%h instr=%h expected 1 100 %h", s_valid, s_pc, s_instr, 32'h100 ^ KEY);
      end
      repeat (4) step();
   endtask

   task automatic test_redirect_pop();
      int lat;
      lat = -1;
      do_reset();
      id_ready = 1'b1;
      repeat (5) step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_2000;
      step();
      for (int i = 1; i <= 6; i++) begin
         step();
         if (s_valid === 1'b1 && lat < 0) begin
            lat = i;
            checks++;
            if (s_pc !== 32'h2000) begin
               failures++;
               $display("FAIL rp_pc got %h expected 2000", s_pc);
            end
         end
      end
      checks++;
      if (lat != 3) begin
         failures++;
         $display("FAIL rp_latency got %0d expected 3", lat);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a [4];
      exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      do_reset();
      id_ready = 1'b1;
      step();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (s_addr !== exp_a[i] || s_req !== 1'b1) begin
            failures++;
            $display("FAIL wrap i=%0d got req=%b addr=%h expected 1 %h", i, s_req, s_addr, exp_a[i]);
         end
      end
      repeat (4) step();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         id_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) begin
            redirect = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            redirect_pc = $urandom() & 32'hFFFF_FFFC;
`else
            redirect_pc = $urandom();
`endif
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | (redirect_pc & 32'hF);
         end
         step();
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      repeat (3) step();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || id_valid !== 1'b0 || imem_addr !== RESET_PC) begin
         failures++;
         $display("FAIL mid_reset_ctrl got req=%b valid=%b addr=%h expected 0 0 %h", imem_req, id_valid, imem_addr, RESET_PC);
      end
      checks++;
      if (id_instr !== 32'h0 || id_pc !== 32'h0 || id_opcode !== 6'h0) begin
         failures++;
         $display("FAIL mid_reset_data got instr=%h pc=%h op=%h expected 0", id_instr, id_pc, id_opcode);
      end
      do_reset();
      id_ready = 1'b1;
      step();
      checks++;
      if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
         failures++;
         $display("FAIL mid_restart got req=%b addr=%h expected 1 %h", s_req, s_addr, RESET_PC);
      end
      repeat (6) step();
   endtask

`ifdef FETCH_ALIGN_CHECK_EN
   task automatic test_misaligned();
      do_reset();
      id_ready = 1'b1;
      repeat (3) step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (misaligned !== 1'b1 || s_req !== 1'b0 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign i=%0d got mis=%b req=%b valid=%b expected 1 0 0", i, misaligned, s_req, s_valid);
         end
      end
   endtask
`endif

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      id_ready    = 1'b0;
      imem_rdata  = 32'h0;
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_pop();
      test_wrap();
      test_random();
      test_reset_midstream();
`ifdef FETCH_ALIGN_CHECK_EN
      test_misaligned();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
